instruction_fetch_buffered: RTL and testbench
=============================================

// Module: instruction_fetch_buffered
// PURPOSE
//   Parametrised next-generation fetch stage: PC register, request to a synchronous
//   instruction memory, prefetch FIFO, IF/ID output register with valid bit.
//   Adds reset, decode stall, redirect-flush and prefetch buffering; the current fetch lacks these.
//   Sits between the branch-resolve stage (pc_salto/PCSrc) and decode.
// PARAMETERS
//   ADDR_WIDTH  11     PC / instruction-memory address width
//   DATA_WIDTH  32     instruction width
//   PC_STEP     1      PC increment per instruction (word addressing)
//   RESET_PC    0      PC value loaded on reset
//   FIFO_DEPTH  4      prefetch entries; power of two, >= 2
//   NOP_INSTR   32'h0  instruction driven while valid=0
// PORTS
//   clock             in   1           rising-edge clock
//   reset             in   1           synchronous, active-high
//   pc_salto          in   ADDR_WIDTH  redirect target
//   PCSrc             in   1           redirect request, 1-cycle pulse
//   stall             in   1           decode cannot accept; IF/ID holds
//   mem_addr          out  ADDR_WIDTH  memory address (= pc_q, combinational)
//   mem_rd_en         out  1           memory read strobe (combinational)
//   mem_rdata         in   DATA_WIDTH  read data, valid the cycle after mem_rd_en
//   instruccion       out  DATA_WIDTH  IF/ID instruction
//   pc                out  ADDR_WIDTH  IF/ID: fetch address + PC_STEP
//   valid             out  1           IF/ID holds a real instruction
//   current_pc_debug  out  8           pc_q[7:0]
// BEHAVIOUR
// - Reset (sync, dominates all inputs): pc_q=RESET_PC, FIFO empty, inflight=0,
//   valid=0, instruccion=NOP_INSTR, pc=0, mem_rd_en=0 while reset=1.
// - Issue: mem_rd_en = !reset && !PCSrc && (fifo_count + inflight < FIFO_DEPTH).
//   On an issue edge: pc_q <= pc_q+PC_STEP, inflight<=1, tag latched = pc_q.
//   Arithmetic is modulo 2^ADDR_WIDTH; max address wraps to 0 silently.
// - Response: the cycle after issue, mem_rdata+tag is the return beat.
//   Return beat goes to IF/ID directly if FIFO empty and stall=0, else pushes to FIFO.
// - IF/ID update when stall=0: load FIFO head (pop) if non-empty, else return beat
//   if present, else valid<=0, instruccion<=NOP_INSTR. When stall=1: hold all three outputs.
// - FIFO cannot overflow: issue gating reserves a slot for the in-flight beat.
//   Simultaneous push and pop on the same edge is legal; count is unchanged.
// - Redirect (PCSrc=1): pc_q<=pc_salto; FIFO cleared; in-flight beat discarded via an
//   epoch bit; valid<=0, instruccion<=NOP_INSTR regardless of stall. No issue that cycle.
//   Redirect overrides stall and any same-cycle push/pop.
// - Latency: first issue the cycle after reset release. Its instruction is valid after
//   the 2nd edge following release. Redirect target is valid 2 edges after the redirect edge.
// - No state machine beyond: pc_q, inflight, epoch, FIFO pointers/count, IF/ID register.
// STRUCTURE
// - Package fetch_pkg: NOP_INSTR default, the fetch_entry_t struct {instr, pc_plus} and
//   a pc_next() increment-with-wrap function.
// - One sub-module: fetch_fifo (DEPTH, WIDTH; push, pop, clear, count, head).
//   It is synchronous-reset and its clear has priority over push/pop.
// TESTING
// - Reset, stall=0, mem[i]=i+100 -> valid rises on edge 2.
//   Outputs 100,101,102.. with pc=1,2,3.. and one instruction per cycle.
// - stall=1 for 8 cycles -> outputs hold; mem_rd_en drops after 4 issues (FIFO full).
//   On release, 5 consecutive instructions are delivered with no gap or duplicate.
// - PCSrc with pc_salto=0x40 during steady streaming -> next edge valid=0.
//   The wrong-path in-flight beat never appears; mem[0x40] is at output 2 edges later.
// - PCSrc together with stall=1 and a full FIFO -> FIFO empties and valid=0.
//   Target fetch then begins.
// - Start at pc 0x7FE (ADDR_WIDTH=11) -> fetches 0x7FE,0x7FF,0x000; pc outputs 0x7FF,0x000,0x001.
// - Assert reset mid-stream with stall=1 -> next edge all outputs at reset values.
//   First instruction after release is mem[RESET_PC].

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the buffered instruction-fetch stage.
package fetch_pkg;

   localparam int unsigned FETCH_ADDR_W = 11;
   localparam int unsigned FETCH_DATA_W = 32;

   // Instruction driven on the IF/ID register while it holds no real instruction.
   localparam logic [FETCH_DATA_W-1:0] NOP_INSTR_DEFAULT = 32'h0;

   // One fetched instruction together with the address of its successor,
   // shown at the default widths of the fetch stage.
   typedef struct packed {
      logic [FETCH_DATA_W-1:0] instr;
      logic [FETCH_ADDR_W-1:0] pc_plus;
   } fetch_entry_t;

   // PC increment modulo 2^width; the top address silently wraps to zero.
   function automatic logic [31:0] pc_next(input logic [31:0] pc,
                                           input int unsigned step,
                                           input int unsigned width);
      logic [31:0] mask;
      logic [31:0] sum;
      mask = (32'd1 << width) - 32'd1;
      sum  = pc + step;
      return sum & mask;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: power-of-two depth, synchronous reset, clear beats push/pop.
module fetch_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   clear,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       head,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

   logic [WIDTH-1:0] slots_q [DEPTH];
   logic [WIDTH-1:0] slots_d [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             push_ok, pop_ok;

   // Next-state: only legal operations take effect; a full FIFO may push while popping.
   always_comb begin
      pop_ok   = pop && (count_q != '0);
      push_ok  = push && ((count_q != FULL) || pop_ok);
      slots_d  = slots_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (clear) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) begin
            slots_d[wr_ptr_q] = push_data;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
         end
         if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         if (push_ok && !pop_ok) begin
            count_d = count_q + (PTR_W + 1)'(1);
         end else if (pop_ok && !push_ok) begin
            count_d = count_q - (PTR_W + 1)'(1);
         end
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents are meaningless until written, so no reset.
   always_ff @(posedge clock) begin
      slots_q <= slots_d;
   end

   assign head  = slots_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/instruction_fetch_buffered.sv
// Buffered fetch stage: PC register, synchronous memory request, prefetch FIFO
// and IF/ID register with valid bit, decode stall and redirect flush.
module instruction_fetch_buffered
   import fetch_pkg::*;
#(
   parameter int unsigned            ADDR_WIDTH = FETCH_ADDR_W,
   parameter int unsigned            DATA_WIDTH = FETCH_DATA_W,
   parameter int unsigned            PC_STEP    = 1,
   parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0,
   parameter int unsigned            FIFO_DEPTH = 4,
   parameter logic [DATA_WIDTH-1:0]  NOP_INSTR  = DATA_WIDTH'(NOP_INSTR_DEFAULT)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] pc_salto,
   input  logic                  PCSrc,
   input  logic                  stall,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_rd_en,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [DATA_WIDTH-1:0] instruccion,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic                  valid,
   output logic [7:0]            current_pc_debug
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] instr;
      logic [ADDR_WIDTH-1:0] pc_plus;
   } entry_t;

   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [ADDR_WIDTH-1:0] tag_q, tag_d;
   logic                  inflight_q, inflight_d;
   logic                  epoch_q, epoch_d;
   logic                  beat_epoch_q, beat_epoch_d;
   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] instr_q, instr_d;
   logic [ADDR_WIDTH-1:0] pc_out_q, pc_out_d;

   logic [CNT_W-1:0]      fifo_count;
   entry_t                fifo_head;
   entry_t                beat;
   logic [CNT_W:0]        occupancy;
   logic                  issue, beat_vld, fifo_empty, fifo_push, fifo_pop;

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(entry_t))
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .clear     (PCSrc),
      .push      (fifo_push),
      .push_data (beat),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .count     (fifo_count)
   );

   // Issue gating reserves a FIFO slot for the beat still in flight; redirect
   // flushes the FIFO and drops the outstanding beat through the epoch bit.
   always_comb begin
      occupancy     = {1'b0, fifo_count} + (CNT_W + 1)'(inflight_q);
      issue         = !reset && !PCSrc && (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
      beat_vld      = inflight_q && (beat_epoch_q == epoch_q);
      beat.instr    = mem_rdata;
      beat.pc_plus  = ADDR_WIDTH'(pc_next(32'(tag_q), PC_STEP, ADDR_WIDTH));
      fifo_empty    = (fifo_count == '0);
      fifo_pop      = !PCSrc && !stall && !fifo_empty;
      fifo_push     = !PCSrc && beat_vld && (stall || !fifo_empty);

      pc_d          = pc_q;
      tag_d         = tag_q;
      beat_epoch_d  = beat_epoch_q;
      inflight_d    = issue;
      epoch_d       = PCSrc ? ~epoch_q : epoch_q;
      if (PCSrc) begin
         pc_d = pc_salto;
      end else if (issue) begin
         pc_d         = ADDR_WIDTH'(pc_next(32'(pc_q), PC_STEP, ADDR_WIDTH));
         tag_d        = pc_q;
         beat_epoch_d = epoch_q;
      end

      valid_d  = valid_q;
      instr_d  = instr_q;
      pc_out_d = pc_out_q;
      if (PCSrc) begin
         valid_d = 1'b0;
         instr_d = NOP_INSTR;
      end else if (!stall) begin
         if (!fifo_empty) begin
            valid_d  = 1'b1;
            instr_d  = fifo_head.instr;
            pc_out_d = fifo_head.pc_plus;
         end else if (beat_vld) begin
            valid_d  = 1'b1;
            instr_d  = beat.instr;
            pc_out_d = beat.pc_plus;
         end else begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
         end
      end
   end

   // PC, request tracking and IF/ID registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         pc_q         <= RESET_PC;
         inflight_q   <= 1'b0;
         epoch_q      <= 1'b0;
         beat_epoch_q <= 1'b0;
         valid_q      <= 1'b0;
         instr_q      <= NOP_INSTR;
         pc_out_q     <= '0;
      end else begin
         pc_q         <= pc_d;
         inflight_q   <= inflight_d;
         epoch_q      <= epoch_d;
         beat_epoch_q <= beat_epoch_d;
         valid_q      <= valid_d;
         instr_q      <= instr_d;
         pc_out_q     <= pc_out_d;
      end
   end

   // Address of the outstanding request; only meaningful while a beat is in flight.
   always_ff @(posedge clock) begin
      tag_q <= tag_d;
   end

   assign mem_addr         = pc_q;
   assign mem_rd_en        = issue;
   assign instruccion      = instr_q;
   assign pc               = pc_out_q;
   assign valid            = valid_q;
   assign current_pc_debug = 8'(pc_q);

endmodule

// File: tb/tb_instruction_fetch_buffered.sv
// Bench for instruction_fetch_buffered: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based model.
module tb_instruction_fetch_buffered;
   import fetch_pkg::*;

   localparam int AW    = 11;
   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int NADDR = 2 ** AW;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          PCSrc = 1'b0;
   logic          stall = 1'b0;
   logic [AW-1:0] pc_salto = '0;
   logic [AW-1:0] mem_addr;
   logic          mem_rd_en;
   logic [DW-1:0] mem_rdata;
   logic [DW-1:0] instruccion;
   logic [AW-1:0] pc;
   logic          valid;
   logic [7:0]    current_pc_debug;

   instruction_fetch_buffered dut (
      .clock            (clock),
      .reset            (reset),
      .pc_salto         (pc_salto),
      .PCSrc            (PCSrc),
      .stall            (stall),
      .mem_addr         (mem_addr),
      .mem_rd_en        (mem_rd_en),
      .mem_rdata        (mem_rdata),
      .instruccion      (instruccion),
      .pc               (pc),
      .valid            (valid),
      .current_pc_debug (current_pc_debug)
   );

   always #5 clock = ~clock;

   // Synchronous instruction memory, mem[i] = i + 100.
   logic [DW-1:0] mem [NADDR];
   initial for (int i = 0; i < NADDR; i++) mem[i] = 32'(i + 100);
   always @(posedge clock) if (mem_rd_en) mem_rdata <= mem[mem_addr];

   int checks = 0;
   int errors = 0;
   bit pre_rd_en;

   // Reference model state: next fetch address, queue of buffered entries,
   // outstanding request and the IF/ID contents.
   int           m_pc = 0;
   fetch_entry_t m_fifo[$];
   bit           m_infl = 0;
   int           m_tag = 0;
   bit           m_valid = 0;
   logic [31:0]  m_instr = 0;
   int           m_pcout = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, check request outputs, clock, advance model, check IF/ID.
   task automatic step(input bit r, input bit s, input bit p, input int t);
      bit           iss;
      fetch_entry_t beat, hd;
      reset    = r;
      stall    = s;
      PCSrc    = p;
      pc_salto = AW'(t);
      #2;
      iss       = !r && !p && (m_fifo.size() + int'(m_infl) < DEPTH);
      pre_rd_en = mem_rd_en;
      chk("mem_rd_en", 32'(mem_rd_en), 32'(iss));
      if (iss) chk("mem_addr", 32'(mem_addr), 32'(m_pc));
      @(posedge clock);
      beat.instr   = mem[m_tag];
      beat.pc_plus = AW'((m_tag + 1) % NADDR);
      if (r) begin
         m_pc = 0; m_fifo.delete(); m_infl = 0;
         m_valid = 0; m_instr = 0; m_pcout = 0;
      end else if (p) begin
         m_pc = t % NADDR; m_fifo.delete(); m_infl = 0;
         m_valid = 0; m_instr = 0;
      end else begin
         if (!s) begin
            if (m_fifo.size() > 0) begin
               hd = m_fifo.pop_front();
               m_valid = 1; m_instr = hd.instr; m_pcout = int'(hd.pc_plus);
               if (m_infl) m_fifo.push_back(beat);
            end else if (m_infl) begin
               m_valid = 1; m_instr = beat.instr; m_pcout = int'(beat.pc_plus);
            end else begin
               m_valid = 0; m_instr = 0;
            end
         end else if (m_infl) begin
            m_fifo.push_back(beat);
         end
         if (iss) begin
            m_tag = m_pc;
            m_pc  = (m_pc + 1) % NADDR;
         end
         m_infl = iss;
      end
      #1;
      chk("valid", 32'(valid), 32'(m_valid));
      chk("instr", instruccion, m_instr);
      if (m_valid) chk("pc", 32'(pc), 32'(m_pcout));
      chk("pc_debug", 32'(current_pc_debug), 32'(m_pc & 255));
   endtask

   typedef struct {
      bit          rst, stl, src;
      int          salto;
      bit          exp_rd;
      bit          exp_valid;
      logic [31:0] exp_instr;
      int          exp_pc;
   } vec_t;

   function automatic vec_t mk(bit r, bit s, bit p, int t, bit rd, bit v, logic [31:0] ins, int pcv);
      vec_t x;
      x.rst = r; x.stl = s; x.src = p; x.salto = t;
      x.exp_rd = rd; x.exp_valid = v; x.exp_instr = ins; x.exp_pc = pcv;
      return x;
   endfunction

   vec_t tbl[22];

   initial begin
      // Directed stream: reset, fill, 8-cycle stall, release, redirect to 0x40.
      tbl[0]  = mk(1, 0, 0, 0,    0, 0, 0,   0);
      tbl[1]  = mk(0, 0, 0, 0,    1, 0, 0,   0);
      tbl[2]  = mk(0, 0, 0, 0,    1, 1, 100, 1);
      tbl[3]  = mk(0, 0, 0, 0,    1, 1, 101, 2);
      tbl[4]  = mk(0, 0, 0, 0,    1, 1, 102, 3);
      for (int i = 5; i <= 7; i++)  tbl[i] = mk(0, 1, 0, 0, 1, 1, 102, 3);
      for (int i = 8; i <= 12; i++) tbl[i] = mk(0, 1, 0, 0, 0, 1, 102, 3);
      tbl[13] = mk(0, 0, 0, 0,    0, 1, 103, 4);
      tbl[14] = mk(0, 0, 0, 0,    1, 1, 104, 5);
      tbl[15] = mk(0, 0, 0, 0,    1, 1, 105, 6);
      tbl[16] = mk(0, 0, 0, 0,    1, 1, 106, 7);
      tbl[17] = mk(0, 0, 0, 0,    1, 1, 107, 8);
      tbl[18] = mk(0, 0, 1, 'h40, 0, 0, 0,   0);
      tbl[19] = mk(0, 0, 0, 0,    1, 0, 0,   0);
      tbl[20] = mk(0, 0, 0, 0,    1, 1, 164, 'h41);
      tbl[21] = mk(0, 0, 0, 0,    1, 1, 165, 'h42);

      for (int i = 0; i < 22; i++) begin
         step(tbl[i].rst, tbl[i].stl, tbl[i].src, tbl[i].salto);
         chk($sformatf("tbl%0d_rd_en", i), 32'(pre_rd_en), 32'(tbl[i].exp_rd));
         chk($sformatf("tbl%0d_valid", i), 32'(valid), 32'(tbl[i].exp_valid));
         chk($sformatf("tbl%0d_instr", i), instruccion, tbl[i].exp_instr);
         if (tbl[i].exp_valid) chk($sformatf("tbl%0d_pc", i), 32'(pc), 32'(tbl[i].exp_pc));
         if (tbl[i].rst) chk($sformatf("tbl%0d_rst_pc", i), 32'(pc), 32'h0);
      end

      // Redirect under stall with a full prefetch FIFO.
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      for (int i = 0; i < 7; i++) step(0, 1, 0, 0);
      chk("full_rd_en_low", 32'(pre_rd_en), 32'h0);
      step(0, 1, 1, 'h100);
      chk("flush_valid", 32'(valid), 32'h0);
      chk("flush_instr", instruccion, 32'h0);
      step(0, 1, 0, 0);
      chk("flush_empty_rd_en", 32'(pre_rd_en), 32'h1);
      chk("flush_hold_valid", 32'(valid), 32'h0);
      step(0, 0, 0, 0);
      chk("target_instr", instruccion, 32'h100 + 32'd100);
      chk("target_pc", 32'(pc), 32'h101);

      // Address wrap at the top of an 11-bit space.
      step(0, 0, 1, 'h7FE);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("wrap0_instr", instruccion, 32'h7FE + 32'd100);
      chk("wrap0_pc", 32'(pc), 32'h7FF);
      step(0, 0, 0, 0);
      chk("wrap1_instr", instruccion, 32'h7FF + 32'd100);
      chk("wrap1_pc", 32'(pc), 32'h000);
      step(0, 0, 0, 0);
      chk("wrap2_instr", instruccion, 32'd100);
      chk("wrap2_pc", 32'(pc), 32'h001);

      // Reset mid-stream while decode is stalled.
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      step(1, 1, 0, 0);
      chk("mrst_rd_en", 32'(pre_rd_en), 32'h0);
      chk("mrst_valid", 32'(valid), 32'h0);
      chk("mrst_instr", instruccion, 32'h0);
      chk("mrst_pc", 32'(pc), 32'h0);
      step(0, 0, 0, 0);
      chk("mrst_first_addr", 32'(mem_addr), 32'h1);
      step(0, 0, 0, 0);
      chk("mrst_first_instr", instruccion, 32'd100);
      chk("mrst_first_pc", 32'(pc), 32'h1);

      // Randomized traffic against the model.
      for (int i = 0; i < 500; i++) begin
         step($urandom_range(99) == 0,
              $urandom_range(99) < 35,
              $urandom_range(99) < 6,
              int'($urandom_range(NADDR - 1)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
